// File: rtl/alu_issue_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage_pkg
//  Description : Shared widths and encodings for the ALU issue stage (ID/EX)
//                and the ALU itself. Register width, ALU opsel width, register
//                address width, shift-amount width and op_b select encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_stage_pkg;

    localparam int c_reg_width       = 32;
    localparam int c_alu_opsel_width = 6;
    localparam int c_raddr_width     = 5;
    localparam int c_shamt_width     = 5;
    localparam int c_imm_width       = 16;

    // op_b source select
    typedef logic [1:0] b_sel_t;
    localparam b_sel_t c_b_sel_rt    = 2'd0;
    localparam b_sel_t c_b_sel_imm   = 2'd1;
    localparam b_sel_t c_b_sel_shamt = 2'd2;
    localparam b_sel_t c_b_sel_rsvd  = 2'd3;   // drives op_b to zero

endpackage : alu_issue_stage_pkg
`default_nettype wire

// File: rtl/alu_issue_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage_fwd_mux
//  Description : Operand forwarding mux for one source register. Picks the
//                EX result, the MEM/WB write data or the regfile value, in that
//                priority. Register 0 is never forwarded.
//  Ports       : i_src_addr  - source register address
//                i_rf_data   - regfile read value
//                i_ex_en     - EX stage holds a forwardable result
//                i_ex_rd     - EX destination register
//                i_ex_data   - EX (ALU) result
//                i_mem_we    - MEM/WB writes a register
//                i_mem_rd    - MEM/WB destination register
//                i_mem_data  - MEM/WB write data
//                o_data      - forwarded operand value
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage_fwd_mux #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] i_src_addr,
    input  logic [DATA_W-1:0]  i_rf_data,
    input  logic               i_ex_en,
    input  logic [RADDR_W-1:0] i_ex_rd,
    input  logic [DATA_W-1:0]  i_ex_data,
    input  logic               i_mem_we,
    input  logic [RADDR_W-1:0] i_mem_rd,
    input  logic [DATA_W-1:0]  i_mem_data,
    output logic [DATA_W-1:0]  o_data
);

    logic w_ex_hit;
    logic w_mem_hit;

    assign w_ex_hit  = i_ex_en  && (i_ex_rd  != '0) && (i_ex_rd  == i_src_addr);
    assign w_mem_hit = i_mem_we && (i_mem_rd != '0) && (i_mem_rd == i_src_addr);

    always_comb begin
        o_data = i_rf_data;
        if (w_ex_hit) begin
            o_data = i_ex_data;
        end else if (w_mem_hit) begin
            o_data = i_mem_data;
        end
    end

endmodule : alu_issue_stage_fwd_mux
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : ID/EX pipeline register in front of the ALU. Selects and
//                forwards operands, inserts a bubble on load-use, honours a
//                downstream hold and a branch flush.
//  Ports       : clk, rst (sync, active high)
//                id_*        - decoded instruction from ID
//                ex_alu_result - ALU output, EX forward source
//                mem_we/mem_rd/mem_data - MEM/WB forward source
//                hold, flush - stall / kill controls
//                id_stall    - decode must hold its instruction (comb.)
//                ex_*        - registered ALU operands and controls
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_W  = c_reg_width,
    parameter int OPSEL_W = c_alu_opsel_width,
    parameter int RADDR_W = c_raddr_width,
    parameter int SHAMT_W = c_shamt_width
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs_addr,
    input  logic [RADDR_W-1:0] id_rt_addr,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [15:0]        id_imm,
    input  logic               id_imm_zext,
    input  logic [SHAMT_W-1:0] id_shamt,
    input  logic               id_a_sel,
    input  logic [1:0]         id_b_sel,
    input  logic [OPSEL_W-1:0] id_alu_opsel,
    input  logic [RADDR_W-1:0] id_rd_addr,
    input  logic               id_we,
    input  logic               id_is_load,
    input  logic [DATA_W-1:0]  ex_alu_result,
    input  logic               mem_we,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic               hold,
    input  logic               flush,
    output logic               id_stall,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_op_a,
    output logic [DATA_W-1:0]  ex_op_b,
    output logic [OPSEL_W-1:0] ex_alu_opsel,
    output logic [RADDR_W-1:0] ex_rd_addr,
    output logic               ex_we,
    output logic               ex_is_load
);

    // ID/EX register state
    logic               r_ex_valid_q,   w_ex_valid_d;
    logic [DATA_W-1:0]  r_ex_op_a_q,    w_ex_op_a_d;
    logic [DATA_W-1:0]  r_ex_op_b_q,    w_ex_op_b_d;
    logic [OPSEL_W-1:0] r_ex_opsel_q,   w_ex_opsel_d;
    logic [RADDR_W-1:0] r_ex_rd_q,      w_ex_rd_d;
    logic               r_ex_we_q,      w_ex_we_d;
    logic               r_ex_is_load_q, w_ex_is_load_d;

    logic              w_ex_fwd_en;
    logic [DATA_W-1:0] w_rs_fwd;
    logic [DATA_W-1:0] w_rt_fwd;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_shamt_ext;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic              w_ex_load_dest;
    logic              w_load_use;

    // A load in EX has no data yet, so it cannot be a forward source.
    assign w_ex_fwd_en = r_ex_valid_q && r_ex_we_q && !r_ex_is_load_q;

    alu_issue_stage_fwd_mux #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_fwd_rs (
        .i_src_addr (id_rs_addr),
        .i_rf_data  (id_rs_data),
        .i_ex_en    (w_ex_fwd_en),
        .i_ex_rd    (r_ex_rd_q),
        .i_ex_data  (ex_alu_result),
        .i_mem_we   (mem_we),
        .i_mem_rd   (mem_rd),
        .i_mem_data (mem_data),
        .o_data     (w_rs_fwd)
    );

    alu_issue_stage_fwd_mux #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_fwd_rt (
        .i_src_addr (id_rt_addr),
        .i_rf_data  (id_rt_data),
        .i_ex_en    (w_ex_fwd_en),
        .i_ex_rd    (r_ex_rd_q),
        .i_ex_data  (ex_alu_result),
        .i_mem_we   (mem_we),
        .i_mem_rd   (mem_rd),
        .i_mem_data (mem_data),
        .o_data     (w_rt_fwd)
    );

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign w_ex_load_dest = r_ex_valid_q && r_ex_is_load_q && r_ex_we_q &&
                            (r_ex_rd_q != '0);
    assign w_load_use = id_valid && w_ex_load_dest &&
                        ((id_uses_rs && (id_rs_addr == r_ex_rd_q)) ||
                         (id_uses_rt && (id_rt_addr == r_ex_rd_q)));

    // A flushed instruction is discarded anyway, so a load-use on it
    // must not stall decode.
    assign id_stall = !rst && (hold || (w_load_use && !flush));

    // ------------------------------------------------------------------
    // Operand select
    // ------------------------------------------------------------------
    assign w_imm_ext   = id_imm_zext ? {{(DATA_W-16){1'b0}}, id_imm}
                                     : {{(DATA_W-16){id_imm[15]}}, id_imm};
    assign w_shamt_ext = {{(DATA_W-SHAMT_W){1'b0}}, id_shamt};
    assign w_op_a      = id_a_sel ? w_rt_fwd : w_rs_fwd;

    always_comb begin
        w_op_b = '0;
        case (id_b_sel)
            c_b_sel_rt:    w_op_b = w_rt_fwd;
            c_b_sel_imm:   w_op_b = w_imm_ext;
            c_b_sel_shamt: w_op_b = w_shamt_ext;
            default:       w_op_b = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // ID/EX next state: hold > flush > load-use bubble > normal load
    // ------------------------------------------------------------------
    always_comb begin
        w_ex_valid_d   = r_ex_valid_q;
        w_ex_op_a_d    = r_ex_op_a_q;
        w_ex_op_b_d    = r_ex_op_b_q;
        w_ex_opsel_d   = r_ex_opsel_q;
        w_ex_rd_d      = r_ex_rd_q;
        w_ex_we_d      = r_ex_we_q;
        w_ex_is_load_d = r_ex_is_load_q;
        if (hold) begin
            // keep every register
        end else if (flush || w_load_use) begin
            w_ex_valid_d   = 1'b0;
            w_ex_op_a_d    = '0;
            w_ex_op_b_d    = '0;
            w_ex_opsel_d   = '0;
            w_ex_rd_d      = '0;
            w_ex_we_d      = 1'b0;
            w_ex_is_load_d = 1'b0;
        end else begin
            w_ex_valid_d   = id_valid;
            w_ex_op_a_d    = w_op_a;
            w_ex_op_b_d    = w_op_b;
            w_ex_opsel_d   = id_alu_opsel;
            w_ex_rd_d      = id_rd_addr;
            w_ex_we_d      = id_valid && id_we;
            w_ex_is_load_d = id_valid && id_is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid_q   <= 1'b0;
            r_ex_op_a_q    <= '0;
            r_ex_op_b_q    <= '0;
            r_ex_opsel_q   <= '0;
            r_ex_rd_q      <= '0;
            r_ex_we_q      <= 1'b0;
            r_ex_is_load_q <= 1'b0;
        end else begin
            r_ex_valid_q   <= w_ex_valid_d;
            r_ex_op_a_q    <= w_ex_op_a_d;
            r_ex_op_b_q    <= w_ex_op_b_d;
            r_ex_opsel_q   <= w_ex_opsel_d;
            r_ex_rd_q      <= w_ex_rd_d;
            r_ex_we_q      <= w_ex_we_d;
            r_ex_is_load_q <= w_ex_is_load_d;
        end
    end

    assign ex_valid     = r_ex_valid_q;
    assign ex_op_a      = r_ex_op_a_q;
    assign ex_op_b      = r_ex_op_b_q;
    assign ex_alu_opsel = r_ex_opsel_q;
    assign ex_rd_addr   = r_ex_rd_q;
    assign ex_we        = r_ex_we_q;
    assign ex_is_load   = r_ex_is_load_q;

endmodule : alu_issue_stage
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_stage
//  Description : Self-checking bench for alu_issue_stage. Directed
//                instructions push their expected EX contents into a
//                scoreboard queue; a monitor pops and compares whenever EX
//                presents a new valid instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [5:0]  opsel;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs_addr, id_rt_addr;
    logic        id_uses_rs, id_uses_rt;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic        id_imm_zext;
    logic [4:0]  id_shamt;
    logic        id_a_sel;
    logic [1:0]  id_b_sel;
    logic [5:0]  id_alu_opsel;
    logic [4:0]  id_rd_addr;
    logic        id_we, id_is_load;
    logic [31:0] ex_alu_result;
    logic        mem_we;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        hold, flush;
    logic        id_stall, ex_valid;
    logic [31:0] ex_op_a, ex_op_b;
    logic [5:0]  ex_alu_opsel;
    logic [4:0]  ex_rd_addr;
    logic        ex_we, ex_is_load;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs_addr    (id_rs_addr),
        .id_rt_addr    (id_rt_addr),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .id_imm        (id_imm),
        .id_imm_zext   (id_imm_zext),
        .id_shamt      (id_shamt),
        .id_a_sel      (id_a_sel),
        .id_b_sel      (id_b_sel),
        .id_alu_opsel  (id_alu_opsel),
        .id_rd_addr    (id_rd_addr),
        .id_we         (id_we),
        .id_is_load    (id_is_load),
        .ex_alu_result (ex_alu_result),
        .mem_we        (mem_we),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .hold          (hold),
        .flush         (flush),
        .id_stall      (id_stall),
        .ex_valid      (ex_valid),
        .ex_op_a       (ex_op_a),
        .ex_op_b       (ex_op_b),
        .ex_alu_opsel  (ex_alu_opsel),
        .ex_rd_addr    (ex_rd_addr),
        .ex_we         (ex_we),
        .ex_is_load    (ex_is_load)
    );

    function automatic exp_t dut_ex();
        exp_t e;
        e.op_a  = ex_op_a;
        e.op_b  = ex_op_b;
        e.opsel = ex_alu_opsel;
        e.rd    = ex_rd_addr;
        e.we    = ex_we;
        e.ld    = ex_is_load;
        return e;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op,
                        input logic [4:0] rd, input logic we, input logic ld);
        exp_t e;
        e.op_a = a; e.op_b = b; e.opsel = op; e.rd = rd; e.we = we; e.ld = ld;
        exp_q.push_back(e);
    endtask

    // Monitor: a new EX instruction appears after an edge that was neither
    // reset nor hold.
    task automatic monitor_loop();
        logic skip;
        exp_t e;
        forever begin
            @(posedge clk);
            skip = rst | hold;
            @(negedge clk);
            if (ex_valid && !skip) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ex_output", {1'b0, dut_ex()}, 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ex_contents", {1'b0, dut_ex()}, {1'b0, e});
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_imm_zext = 0; id_shamt = 0;
        id_a_sel = 0; id_b_sel = 0; id_alu_opsel = 0; id_rd_addr = 0; id_we = 0;
        id_is_load = 0;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [31:0] rs_d, input logic urs,
                          input logic [4:0] rt, input logic [31:0] rt_d, input logic urt,
                          input logic a_sel, input logic [1:0] b_sel, input logic [15:0] imm,
                          input logic zext, input logic [4:0] shamt, input logic [5:0] op,
                          input logic [4:0] rd, input logic we, input logic ld);
        id_valid = 1; id_rs_addr = rs; id_rs_data = rs_d; id_uses_rs = urs;
        id_rt_addr = rt; id_rt_data = rt_d; id_uses_rt = urt; id_a_sel = a_sel;
        id_b_sel = b_sel; id_imm = imm; id_imm_zext = zext; id_shamt = shamt;
        id_alu_opsel = op; id_rd_addr = rd; id_we = we; id_is_load = ld;
    endtask

    initial begin
        idle();
        rst = 1; hold = 0; flush = 0; mem_we = 0; mem_rd = 0; mem_data = 0; ex_alu_result = 0;
        fork
            monitor_loop();
        join_none

        // Reset with a valid instruction pending
        set_id(5'd1, 32'h1234, 1, 5'd2, 32'h5678, 1, 0, 2'd0, 16'h0, 0, 5'd0, 6'h3, 5'd4, 1, 0);
        #1;
        chk("stall_in_reset", {127'd0, id_stall}, 128'd0);
        step();
        step();
        chk("reset_valid_we", {126'd0, ex_valid, ex_we}, 128'd0);
        chk("reset_operands", {64'd0, ex_op_a, ex_op_b}, 128'd0);
        rst = 0;
        idle();
        step();

        // addi r3, r1, -4
        set_id(5'd1, 32'd10, 1, 5'd0, 32'd0, 0, 0, 2'd1, 16'hFFFC, 0, 5'd0, 6'h01, 5'd3, 1, 0);
        push(32'd10, 32'hFFFF_FFFC, 6'h01, 5'd3, 1, 0);
        step();

        // producer of r2
        set_id(5'd0, 32'd0, 0, 5'd7, 32'h20, 1, 0, 2'd0, 16'h0, 0, 5'd0, 6'h02, 5'd2, 1, 0);
        push(32'd0, 32'h20, 6'h02, 5'd2, 1, 0);
        step();

        // EX beats MEM beats regfile; zero-extended immediate
        ex_alu_result = 32'h55; mem_we = 1; mem_rd = 5'd2; mem_data = 32'h99;
        set_id(5'd2, 32'h11, 1, 5'd0, 32'd0, 0, 0, 2'd1, 16'h0010, 1, 5'd0, 6'h03, 5'd4, 1, 0);
        push(32'h55, 32'h10, 6'h03, 5'd4, 1, 0);
        step();

        // MEM-only hit on rt used as op_a (shift form), shamt on op_b
        set_id(5'd0, 32'd0, 0, 5'd2, 32'h11, 1, 1, 2'd2, 16'h0, 0, 5'd31, 6'h04, 5'd6, 1, 0);
        push(32'h99, 32'h1F, 6'h04, 5'd6, 1, 0);
        step();

        // EX hit on rs, reserved b_sel gives zero
        ex_alu_result = 32'h1234; mem_we = 0;
        set_id(5'd6, 32'h66, 1, 5'd0, 32'd0, 0, 0, 2'd3, 16'hFFFF, 0, 5'd3, 6'h05, 5'd0, 0, 0);
        push(32'h1234, 32'h0, 6'h05, 5'd0, 0, 0);
        step();

        // Load r5 then a consumer of r5 through rt
        set_id(5'd1, 32'h100, 1, 5'd0, 32'd0, 0, 0, 2'd1, 16'h0008, 0, 5'd0, 6'h00, 5'd5, 1, 1);
        push(32'h100, 32'h8, 6'h00, 5'd5, 1, 1);
        step();
        set_id(5'd1, 32'h100, 1, 5'd5, 32'h3, 1, 0, 2'd0, 16'h0, 0, 5'd0, 6'h07, 5'd8, 1, 0);
        #1;
        chk("load_use_stall", {127'd0, id_stall}, 128'd1);
        step();
        chk("load_use_bubble", {126'd0, ex_valid, ex_we}, 128'd0);
        mem_we = 1; mem_rd = 5'd5; mem_data = 32'd7;
        #1;
        chk("reissue_no_stall", {127'd0, id_stall}, 128'd0);
        push(32'h100, 32'd7, 6'h07, 5'd8, 1, 0);
        step();

        // r0 is never forwarded and never a load-use source
        mem_we = 1; mem_rd = 5'd0; mem_data = 32'hBB;
        set_id(5'd1, 32'h100, 1, 5'd0, 32'd0, 0, 0, 2'd1, 16'h0, 0, 5'd0, 6'h00, 5'd0, 1, 0);
        push(32'h100, 32'h0, 6'h00, 5'd0, 1, 0);
        step();
        ex_alu_result = 32'hAA;
        set_id(5'd0, 32'd0, 1, 5'd0, 32'd0, 0, 0, 2'd1, 16'h0001, 0, 5'd0, 6'h09, 5'd0, 1, 1);
        push(32'h0, 32'h1, 6'h09, 5'd0, 1, 1);
        step();
        set_id(5'd0, 32'd0, 1, 5'd0, 32'd0, 1, 0, 2'd0, 16'h0, 0, 5'd0, 6'h0A, 5'd9, 1, 0);
        #1;
        chk("rd0_load_no_stall", {127'd0, id_stall}, 128'd0);
        push(32'h0, 32'h0, 6'h0A, 5'd9, 1, 0);
        step();
        mem_we = 0;

        // hold + flush: EX frozen, decode stalled
        hold = 1; flush = 1;
        set_id(5'd1, 32'h77, 1, 5'd0, 32'd0, 0, 0, 2'd1, 16'h0002, 0, 5'd0, 6'h0B, 5'd12, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_stall", {127'd0, id_stall}, 128'd1);
            step();
            chk("hold_frozen", {1'b0, ex_valid, 31'd0, dut_ex()},
                {1'b0, 1'b1, 31'd0, 32'h0, 32'h0, 6'h0A, 5'd9, 1'b1, 1'b0});
        end
        hold = 0;
        #1;
        chk("flush_no_stall", {127'd0, id_stall}, 128'd0);
        step();
        chk("flush_bubble", {1'b0, ex_valid, 31'd0, dut_ex()}, 128'd0);
        flush = 0;
        push(32'h77, 32'h2, 6'h0B, 5'd12, 1, 0);
        step();

        // Reset mid-operation overrides hold
        hold = 1; rst = 1;
        step();
        chk("reset_over_hold", {1'b0, ex_valid, 31'd0, dut_ex()}, 128'd0);
        rst = 0; hold = 0;
        idle();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        step();
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_alu_issue_stage
`default_nettype wire
